rsa_modexp_ctrl: RTL and testbench
==================================

Name: rsa_modexp_ctrl

Overview:
- Sequencer for RSA modular exponentiation m = C^d mod n.
- Sits between the OS2IP and I2OSP stages of the decrypt/encrypt datapaths.
- Scans the exponent MSB-first with left-to-right square-and-multiply.
- Drives a single external modular multiplier through a start/done handshake and owns the accumulator and operand registers.

Parameters:
- WIDTH, 256, bit width of base, modulus, accumulator and result.
- EXP_BITS, 256, bit width of the exponent; the bit index counter is clog2(EXP_BITS) wide.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ready  in  1  start request; base/exp/n sampled on the cycle ready=1 is accepted.
- base  in  WIDTH  integer base, C from OS2IP.
- exp  in  EXP_BITS  exponent d or e.
- n  in  WIDTH  modulus.
- result  out  WIDTH  base^exp mod n.
- valid  out  1  result valid.
- busy  out  1  operation in progress.
- mm_start  out  1  one-cycle pulse launching a modular multiply.
- mm_a  out  WIDTH  multiplier operand A.
- mm_b  out  WIDTH  multiplier operand B.
- mm_n  out  WIDTH  multiplier modulus; equals the latched n.
- mm_done  in  1  one-cycle pulse; mm_p is valid in the same cycle.
- mm_p  in  WIDTH  (mm_a*mm_b) mod mm_n.

Behaviour:
- Reset values: result=0, valid=0, busy=0, mm_start=0, mm_a=0, mm_b=0, mm_n=0, state=IDLE.
- States: IDLE, SCAN, MUL, MUL_W, SQR, SQR_W, NEXT, DONE.
- IDLE:
  - On ready=1: latch base, exp and n; set busy=1, valid=0, acc=1, idx=EXP_BITS-1; go to SCAN.
  - ready is ignored in every state other than IDLE and DONE.
- SCAN (leading-zero skip), one bit per cycle:
  - If exp[idx]=1, go to MUL.
  - Else if idx=0, the exponent is zero: acc stays 1; go to DONE.
  - Else idx <= idx-1.
- MUL: assert mm_start for 1 cycle with mm_a=acc, mm_b=base; go to MUL_W.
- MUL_W: wait for mm_done, then acc <= mm_p; go to NEXT.
  - The first MUL computes 1*base mod n, which reduces a base that is >= n.
- NEXT:
  - If idx=0, go to DONE.
  - Else idx <= idx-1; go to SQR.
- SQR: assert mm_start for 1 cycle with mm_a=mm_b=acc; go to SQR_W.
- SQR_W: wait for mm_done, then acc <= mm_p.
  - If exp[idx]=1, go to MUL; else go to NEXT.
- DONE:
  - result <= acc, except result <= 0 when n<=1 (n=0 or n=1). valid=1, busy=0.
  - valid and result hold until the next accepted ready or reset.
  - ready in DONE behaves exactly as in IDLE: valid drops the next cycle.
- Multiplier handshake:
  - mm_a, mm_b and mm_n stay stable from mm_start until mm_done.
  - Only one multiply is outstanding at any time.
  - No timeout; the multiplier latency is unbounded.
- mm_done outside MUL_W/SQR_W is ignored, including a late done after a reset.
- Reset mid-operation: next state IDLE, all outputs return to reset values; the in-flight multiply is abandoned.
- Latency from ready to valid:
  - 2 cycles + (EXP_BITS-1-msb_index) scan cycles.
  - Plus, per multiply operation: 2 cycles + multiplier latency.
  - Plus 1 NEXT cycle per processed bit.
- Multiply count: popcount(exp) multiplies + msb_index squarings.

Optional Feature:
- Macro MODEXP_CONST_TIME_EN, for side-channel hardening.
- Defined:
  - SCAN is bypassed: idx starts at EXP_BITS-1 with acc=1.
  - Every bit performs SQR then MUL regardless of exp[idx]; on a zero bit the MUL product is discarded and acc is unchanged.
  - Exactly 2*EXP_BITS multiplies per operation; latency is independent of exp.
  - exp=0 yields 1 through the normal path.
- Undefined: variable-time behaviour as described in Behaviour.

Test Plan:
1. WIDTH=16, EXP_BITS=16, behavioural multiplier with 3-cycle latency; base=4, exp=13, n=497, ready pulse -> valid=1, result=445, exactly 6 mm_start pulses (1 initial MUL, 3 SQR, 2 MUL); busy low after completion.
2. exp=0, base=7, n=11 -> result=1 after 16 SCAN cycles with no mm_start; n=1, base=5, exp=3 -> result=0.
3. base=500 (> n=497), exp=1 -> result=3; base=0, exp=5, n=497 -> result=0.
4. ready pulsed again while busy during test 1 -> ignored, result still 445; ready asserted in DONE -> valid drops the next cycle and the new operation starts.
5. reset asserted during SQR_W, with mm_done arriving 2 cycles later -> outputs at reset values, state IDLE, stray mm_done ignored; a following clean run with base=4, exp=13, n=497 returns 445.
6. MODEXP_CONST_TIME_EN defined, base=4, exp=13, n=497 -> result=445, exactly 32 mm_start pulses; exp=0x0001 and exp=0xFFFF take an identical number of cycles.

Source files
------------

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl
// Sequencer for RSA modular exponentiation result = base^exp mod n using
// MSB-first (left-to-right) square-and-multiply. It drives a single external
// modular multiplier through a start/done handshake and owns the accumulator
// and the latched operands.
//
// Build option: define MODEXP_CONST_TIME_EN for side-channel hardened
// operation. Leading-zero skipping is disabled and every exponent bit costs a
// square followed by a multiply, so latency does not depend on the exponent.
module rsa_modexp_ctrl #(
  parameter int WIDTH    = 256,
  parameter int EXP_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready,
  input  logic [WIDTH-1:0]    base,
  input  logic [EXP_BITS-1:0] exp,
  input  logic [WIDTH-1:0]    n,
  output logic [WIDTH-1:0]    result,
  output logic                valid,
  output logic                busy,
  output logic                mm_start,
  output logic [WIDTH-1:0]    mm_a,
  output logic [WIDTH-1:0]    mm_b,
  output logic [WIDTH-1:0]    mm_n,
  input  logic                mm_done,
  input  logic [WIDTH-1:0]    mm_p
);

  localparam int               IDX_W    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WIDTH-1:0] ACC_ONE  = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    MUL,
    MUL_W,
    SQR,
    SQR_W,
    NEXT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    base_q, base_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]    n_q, n_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                mm_start_q, mm_start_d;
  logic [WIDTH-1:0]    mm_a_q, mm_a_d;
  logic [WIDTH-1:0]    mm_b_q, mm_b_d;

  // A done pulse is only meaningful once the launch pulse has been seen by
  // the multiplier; one in the launch cycle itself cannot belong to us.
  logic mm_ack;
  assign mm_ack = mm_done & ~mm_start_q;

  // Next-state, datapath and output decode for the exponentiation sequence.
  always_comb begin
    logic done_go;
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    n_d        = n_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    result_d   = result_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    done_go    = 1'b0;

    case (state_q)
      // A finished result is held in DONE; a new request is accepted there
      // exactly as from IDLE.
      IDLE, DONE: begin
        if (ready) begin
          base_d  = base;
          exp_d   = exp;
          n_d     = n;
          acc_d   = ACC_ONE;
          idx_d   = IDX_LAST;
          busy_d  = 1'b1;
          valid_d = 1'b0;
`ifdef MODEXP_CONST_TIME_EN
          state_d = SQR;
`else
          state_d = SCAN;
`endif
        end
      end

      // Skip leading zero bits; an all-zero exponent finishes with acc=1.
      SCAN: begin
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          done_go = 1'b1;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end

      MUL: begin
        mm_start_d = 1'b1;
        mm_a_d     = acc_q;
        mm_b_d     = base_q;
        state_d    = MUL_W;
      end

      MUL_W: begin
        if (mm_ack) begin
`ifdef MODEXP_CONST_TIME_EN
          // Dummy multiply on a zero bit: product is thrown away.
          if (exp_q[idx_q]) begin
            acc_d = mm_p;
          end
`else
          acc_d = mm_p;
`endif
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (idx_q == '0) begin
          done_go = 1'b1;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          state_d = SQR;
        end
      end

      SQR: begin
        mm_start_d = 1'b1;
        mm_a_d     = acc_q;
        mm_b_d     = acc_q;
        state_d    = SQR_W;
      end

      SQR_W: begin
        if (mm_ack) begin
          acc_d = mm_p;
`ifdef MODEXP_CONST_TIME_EN
          state_d = MUL;
`else
          state_d = exp_q[idx_q] ? MUL : NEXT;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Publish the result; any value mod 0 or mod 1 is reported as 0.
    if (done_go) begin
      state_d  = DONE;
      result_d = (n_q <= ACC_ONE) ? '0 : acc_d;
      valid_d  = 1'b1;
      busy_d   = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any in-flight multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
    end
  end

  assign result   = result_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_n     = n_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl with WIDTH=EXP_BITS=16 and a 3-cycle multiplier.
// Expected results come from a plain modular-power model; expected latency
// and multiply counts come from the documented timing rules.
`timescale 1ns/1ps
module tb_rsa_modexp_ctrl;

  localparam int W   = 16;
  localparam int EB  = 16;
  localparam int LAT = 3;
`ifdef MODEXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  localparam int M_UNK  = 0;
  localparam int M_IDLE = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic [W-1:0]  base, exp, n;
  logic [W-1:0]  result;
  logic          valid, busy;
  logic          mm_start;
  logic [W-1:0]  mm_a, mm_b, mm_n;
  logic          mm_done = 1'b0;
  logic [W-1:0]  mm_p = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  rsa_modexp_ctrl #(.WIDTH(W), .EXP_BITS(EB)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .base(base), .exp(exp), .n(n),
    .result(result), .valid(valid), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_p(mm_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint ref_modexp(input longint b, input logic [15:0] e, input longint m);
    longint r, x;
    if (m <= 1) return 0;
    r = 1;
    x = b % m;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r;
  endfunction

  function automatic int msb_of(input logic [15:0] e);
    int p = -1;
    for (int i = 0; i < 16; i++) if (e[i]) p = i;
    return p;
  endfunction

  function automatic int n_mults(input logic [15:0] e);
    if (CT) return 2 * EB;
    if (e == 0) return 0;
    return $countones(e) + msb_of(e);
  endfunction

  // Cycles from the ready-accept cycle to the first cycle with valid=1.
  function automatic int lat_of(input logic [15:0] e);
    int msb;
    if (CT) return 1 + EB * (2 * (LAT + 2) + 1);
    if (e == 0) return EB + 1;
    msb = msb_of(e);
    return 2 + (EB - 1 - msb) + n_mults(e) * (LAT + 2) + (msb + 1);
  endfunction

  int     m_mode = M_UNK;
  int     m_cnt, m_lat, m_mults, m_start_base, m_done_cycles;
  int     m_resets = 0;
  longint m_res;
  longint m_n;
  int     starts_seen = 0;

  // Model timeline: advances on each active edge from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE;
      m_resets++;
    end else if (ready && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_mode        = M_RUN;
      m_cnt         = 0;
      m_res         = ref_modexp(base, exp, n);
      m_n           = n;
      m_lat         = lat_of(exp);
      m_mults       = n_mults(exp);
      m_start_base  = starts_seen;
    end
    if (m_mode == M_RUN) begin
      m_cnt++;
      if (m_cnt >= m_lat) begin
        m_mode        = M_DONE;
        m_done_cycles = -1;
      end
    end
    if (m_mode == M_DONE) m_done_cycles++;
  end

  // ---------------- behavioural multiplier ----------------
  int           mm_rem = 0;
  bit           mm_pend = 1'b0;
  int           mm_rst_tag;
  logic [W-1:0] pa, pb, pn;

  always @(negedge clk) begin
    longint prod;
    mm_done = 1'b0;
    if (mm_pend) begin
      if (m_resets == mm_rst_tag)
        check("mm_operands_stable", {mm_a, mm_b, mm_n}, {pa, pb, pn});
      mm_rem--;
      if (mm_rem == 0) begin
        prod    = (pn == 0) ? 0 : (longint'(pa) * longint'(pb)) % longint'(pn);
        mm_p    = W'(prod);
        mm_done = 1'b1;
        mm_pend = 1'b0;
      end
    end
    if (mm_start === 1'b1) begin
      check("mm_single_outstanding", mm_pend, 0);
      check("mm_n_latched", mm_n, m_n);
      mm_pend    = 1'b1;
      mm_rem     = LAT;
      pa         = mm_a;
      pb         = mm_b;
      pn         = mm_n;
      mm_rst_tag = m_resets;
      starts_seen++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    case (m_mode)
      M_IDLE: begin
        check("idle_status", {valid, busy, result}, 0);
        check("idle_mm_outputs", {mm_start, mm_a, mm_b, mm_n}, 0);
      end
      M_RUN: check("run_status", {valid, busy}, 2'b01);
      M_DONE: begin
        check("done_status", {valid, busy}, 2'b10);
        check("done_result", result, m_res);
        check("done_no_mm_start", mm_start, 0);
        if (m_done_cycles == 0)
          check("mult_count", starts_seen - m_start_base, m_mults);
      end
      default: ;
    endcase
  end

  // ---------------- driver ----------------
  task automatic start_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] nn);
    base  = b;
    exp   = e;
    n     = nn;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    base  = W'($urandom);
    exp   = W'($urandom);
    n     = W'($urandom);
  endtask

  task automatic wait_done(input string name, input logic [15:0] b, input logic [15:0] e,
                           input logic [15:0] nn, input longint want, output int k);
    k = 0;
    while (valid !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, (k < 2000), 1);
    check(name, result, want);
    $display("op %s: base=%0d exp=%h n=%0d -> result=%0d (want %0d) cycles=%0d",
             name, b, e, nn, result, want, k);
  endtask

  initial begin
    int k, k1, k2, seen;
    reset = 1'b1;
    ready = 1'b0;
    base  = '0;
    exp   = '0;
    n     = '0;

    // Pin the model with hand-computed values.
    check("model_4_13_497", ref_modexp(4, 16'd13, 497), 445);
    check("model_500_1_497", ref_modexp(500, 16'd1, 497), 3);
    check("model_7_0_11", ref_modexp(7, 16'd0, 11), 1);
    check("model_5_3_1", ref_modexp(5, 16'd3, 1), 0);
    check("model_lat_13", lat_of(16'd13), CT ? 177 : 48);
    check("model_mults_13", n_mults(16'd13), CT ? 32 : 6);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic run with a stray ready while busy.
    start_op(16'd4, 16'd13, 16'd497);
    repeat (10) @(negedge clk);
    base = 16'd2; exp = 16'd3; n = 16'd11; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    wait_done("t1_4_13_497", 4, 13, 497, 445, k);
    check("t1_mm_starts", starts_seen - m_start_base, CT ? 32 : 6);
    repeat (3) @(negedge clk);

    // New requests straight out of DONE; boundary operands.
    start_op(16'd7, 16'd0, 16'd11);
    wait_done("t2_exp0", 7, 0, 11, 1, k);
    check("t2_no_mm_start", starts_seen - m_start_base, CT ? 32 : 0);
    start_op(16'd5, 16'd3, 16'd1);
    wait_done("t2_n1", 5, 3, 1, 0, k);
    repeat (2) @(negedge clk);
    start_op(16'd500, 16'd1, 16'd497);
    wait_done("t3_base_gt_n", 500, 1, 497, 3, k);
    start_op(16'd0, 16'd5, 16'd497);
    wait_done("t3_base0", 0, 5, 497, 0, k);
    start_op(16'd9, 16'd0, 16'd0);
    wait_done("t3_n0", 9, 0, 0, 0, k);
    start_op(16'd123, 16'hB5A3, 16'd65521);
    wait_done("t3_mixed", 123, 16'hB5A3, 65521, ref_modexp(123, 16'hB5A3, 65521), k);

    // Latency dependence on the exponent.
    start_op(16'd3, 16'h0001, 16'd497);
    wait_done("t6_exp0001", 3, 16'h0001, 497, 3, k1);
    start_op(16'd3, 16'hFFFF, 16'd497);
    wait_done("t6_expFFFF", 3, 16'hFFFF, 497, ref_modexp(3, 16'hFFFF, 497), k2);
    check("t6_cycle_delta", k2 - k1, CT ? 0 : 150);

    // Reset during a squaring wait, with the done pulse arriving afterwards.
    start_op(16'd4, 16'd13, 16'd497);
    seen = 0;
    k    = 0;
    while (seen < (CT ? 3 : 2) && k < 500) begin
      @(negedge clk);
      k++;
      if (mm_start === 1'b1) seen++;
    end
    check("t5_reach_sqr", seen, CT ? 3 : 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_after_reset", {valid, busy, result, mm_start}, 0);
    start_op(16'd4, 16'd13, 16'd497);
    wait_done("t5_clean_rerun", 4, 13, 497, 445, k);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
